// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register-file access controller: default
//   data/index widths, command opcode encodings and the controller FSM
//   state encoding (also exported on the controller's debug port).
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_SWAP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Command sequencer in front of a posedge-write / negedge-read register
//   file. Accepts READ / WRITE / SWAP commands, drives the register file
//   ports for the required cycles and returns read data.
//
// Ports
//   clock, reset          : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op, cmd_ra, cmd_rb, cmd_wdata
//   rsp_valid/rsp_ready   : response handshake; rsp_data1 (at ra), rsp_data2 (at rb)
//   rf_reg1, rf_reg2      : register file read/write indices
//   rf_writedata          : register file write data
//   rf_regwrite           : register file write enable
//   rf_readdata1/2        : register file read data
//   dbg_state             : current FSM state
//
// Handshakes: a transfer happens at a rising clock edge where valid and
// ready are both 1. The producer holds valid and its payload until then;
// ready never depends combinationally on valid (all outputs are flops).
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [ADDR_W-1:0] rf_reg1,
  output logic [ADDR_W-1:0] rf_reg2,
  output logic [DATA_W-1:0] rf_writedata,
  output logic              rf_regwrite,
  input  logic [DATA_W-1:0] rf_readdata1,
  input  logic [DATA_W-1:0] rf_readdata2,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
  logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
  logic [ADDR_W-1:0] rf_reg1_q, rf_reg1_d;
  logic [ADDR_W-1:0] rf_reg2_q, rf_reg2_d;
  logic [DATA_W-1:0] rf_writedata_q, rf_writedata_d;
  logic              rf_regwrite_q, rf_regwrite_d;

  cmd_op_e op_in;
  logic    cmd_hs;
  logic    rsp_hs;

  assign op_in  = cmd_op_e'(cmd_op);
  assign cmd_hs = cmd_valid & cmd_ready_q;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  // Index 0 can be made read-only by suppressing its write enable.
  function automatic logic wr_allowed(input logic [ADDR_W-1:0] addr);
    return !(ZERO_PROTECT && (addr == '0));
  endfunction

  // All outputs are registered: each *_d is the value the output takes for
  // the cycle that begins at the next edge. rb is not kept separately since
  // rf_reg2_q already holds it for the whole command.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    ra_d           = ra_q;
    wdata_d        = wdata_q;
    cmd_ready_d    = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_data1_d    = rsp_data1_q;
    rsp_data2_d    = rsp_data2_q;
    rf_reg1_d      = rf_reg1_q;
    rf_reg2_d      = rf_reg2_q;
    rf_writedata_d = rf_writedata_q;
    rf_regwrite_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_hs) begin
          op_d    = op_in;
          ra_d    = cmd_ra;
          wdata_d = cmd_wdata;
          unique case (op_in)
            OP_READ, OP_SWAP: begin
              state_d     = ST_RD;
              cmd_ready_d = 1'b0;
              rf_reg1_d   = cmd_ra;
              rf_reg2_d   = cmd_rb;
            end
            OP_WRITE: begin
              state_d        = ST_WR;
              cmd_ready_d    = 1'b0;
              rf_reg1_d      = cmd_ra;
              rf_writedata_d = cmd_wdata;
              rf_regwrite_d  = wr_allowed(cmd_ra);
            end
            default: ; // NOP: consumed, stay ready
          endcase
        end
      end

      ST_RD: begin
        // Register file sampled at the negedge inside this cycle.
        rsp_data1_d = rf_readdata1;
        rsp_data2_d = rf_readdata2;
        if (op_q == OP_SWAP) begin
          // rf_reg1 still holds ra from acceptance.
          state_d        = ST_WR;
          rf_writedata_d = wdata_q;
          rf_regwrite_d  = wr_allowed(ra_q);
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_WR: begin
        // One turnaround cycle with cmd_ready low lets the write land
        // before any following command is accepted.
        state_d = (op_q == OP_SWAP) ? ST_RESP : ST_IDLE;
      end

      ST_RESP: begin
        // First RESP cycle raises rsp_valid; it then holds until taken.
        rsp_valid_d = 1'b1;
        if (rsp_hs) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_NOP;
      ra_q           <= '0;
      wdata_q        <= '0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data1_q    <= '0;
      rsp_data2_q    <= '0;
      rf_reg1_q      <= '0;
      rf_reg2_q      <= '0;
      rf_writedata_q <= '0;
      rf_regwrite_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      ra_q           <= ra_d;
      wdata_q        <= wdata_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data1_q    <= rsp_data1_d;
      rsp_data2_q    <= rsp_data2_d;
      rf_reg1_q      <= rf_reg1_d;
      rf_reg2_q      <= rf_reg2_d;
      rf_writedata_q <= rf_writedata_d;
      rf_regwrite_q  <= rf_regwrite_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data1    = rsp_data1_q;
  assign rsp_data2    = rsp_data2_q;
  assign rf_reg1      = rf_reg1_q;
  assign rf_reg2      = rf_reg2_q;
  assign rf_writedata = rf_writedata_q;
  assign rf_regwrite  = rf_regwrite_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl
//   Directed bench for regfile_access_ctrl with a behavioural 16x16
//   register file (posedge write, negedge read) attached to the rf_* ports.
module tb_regfile_access_ctrl;
  import regfile_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_ra;
  logic [ADDR_W-1:0] cmd_rb;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;
  logic [ADDR_W-1:0] rf_reg1;
  logic [ADDR_W-1:0] rf_reg2;
  logic [DATA_W-1:0] rf_writedata;
  logic              rf_regwrite;
  logic [DATA_W-1:0] rf_readdata1;
  logic [DATA_W-1:0] rf_readdata2;
  state_e            dbg_state;

  logic [DATA_W-1:0]   mem [16];
  logic [2*DATA_W-1:0] exp_q [$];
  int n_cmp;
  int n_fail;

  regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_PROTECT(1'b1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_writedata(rf_writedata),
    .rf_regwrite(rf_regwrite), .rf_readdata1(rf_readdata1),
    .rf_readdata2(rf_readdata2), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- register file model ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h1111);
    mem[0] = 16'h0000;
    mem[1] = 16'h7B18;
    mem[2] = 16'h246B;
    mem[3] = 16'hFF0F;
    mem[4] = 16'hF0FF;
    mem[6] = 16'h6666;
    mem[7] = 16'h00FF;
    rf_readdata1 = '0;
    rf_readdata2 = '0;
  end

  always @(posedge clock) if (rf_regwrite === 1'b1) mem[rf_reg1] <= rf_writedata;

  always @(negedge clock) begin
    rf_readdata1 <= mem[rf_reg1];
    rf_readdata2 <= mem[rf_reg2];
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1; returns just after the accepting edge.
  task automatic send_cmd(input cmd_op_e op, input logic [ADDR_W-1:0] ra,
                          input logic [ADDR_W-1:0] rb, input logic [DATA_W-1:0] wd);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  // Waits (bounded) for rsp_valid; lat counts cycles from the call point.
  task automatic collect_rsp(output logic [DATA_W-1:0] d1, output logic [DATA_W-1:0] d2,
                             output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    d1 = rsp_data1;
    d2 = rsp_data2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rf_regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/we=%b%b%b, required 000", cmd_ready, rsp_valid, rf_regwrite);
    end
    n_cmp++;
    if (rf_reg1 !== 4'd0 || rf_reg2 !== 4'd0 || rf_writedata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rf: reg1=%h reg2=%h wd=%h, required 0 0 0000", rf_reg1, rf_reg2, rf_writedata);
    end
    n_cmp++;
    if (rsp_data1 !== 16'h0 || rsp_data2 !== 16'h0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_rsp: d1=%h d2=%h st=%0d, required 0000 0000 0", rsp_data1, rsp_data2, dbg_state);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_nop();
    send_cmd(OP_NOP, 4'd9, 4'd9, 16'h9999);
    n_cmp++;
    if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE || rf_regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL nop: ready=%b st=%0d we=%b, required 1 0 0", cmd_ready, dbg_state, rf_regwrite);
    end
  endtask

  task automatic test_read();
    logic [DATA_W-1:0] d1, d2;
    logic [2*DATA_W-1:0] e;
    int lat;
    exp_q.push_back({16'h7B18, 16'h246B});
    send_cmd(OP_READ, 4'd1, 4'd2, 16'h0);
    n_cmp++;
    if (rf_reg1 !== 4'd1 || rf_reg2 !== 4'd2 || rf_regwrite !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL read_rd_cycle: reg1=%h reg2=%h we=%b rdy=%b, required 1 2 0 0",
               rf_reg1, rf_reg2, rf_regwrite, cmd_ready);
    end
    collect_rsp(d1, d2, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL read_latency: %0d cycles, required 2", lat);
    end
    n_cmp++;
    if ({d1, d2} !== e) begin
      n_fail++;
      $display("FAIL read_data: %h, required %h", {d1, d2}, e);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_release: valid=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] d1, d2;
    logic [2*DATA_W-1:0] e;
    int lat;
    send_cmd(OP_WRITE, 4'd5, 4'd0, 16'hBEEF);
    n_cmp++;
    if (rf_regwrite !== 1'b1 || rf_reg1 !== 4'd5 || rf_writedata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_wr_cycle: we=%b reg1=%h wd=%h, required 1 5 beef", rf_regwrite, rf_reg1, rf_writedata);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (rf_regwrite !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL write_one_cycle: we=%b ready=%b, required 0 0", rf_regwrite, cmd_ready);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ready_back: ready=%b valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    exp_q.push_back({16'hBEEF, 16'h6666});
    send_cmd(OP_READ, 4'd5, 4'd6, 16'h0);
    collect_rsp(d1, d2, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2 || {d1, d2} !== e) begin
      n_fail++;
      $display("FAIL write_readback: lat=%0d data=%h, required 2 %h", lat, {d1, d2}, e);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_swap();
    logic [DATA_W-1:0] d1, d2;
    logic [2*DATA_W-1:0] e;
    int lat;
    exp_q.push_back({16'hFF0F, 16'hF0FF});
    send_cmd(OP_SWAP, 4'd3, 4'd4, 16'h1234);
    n_cmp++;
    if (rf_regwrite !== 1'b0 || rf_reg1 !== 4'd3 || rf_reg2 !== 4'd4) begin
      n_fail++;
      $display("FAIL swap_rd_cycle: we=%b reg1=%h reg2=%h, required 0 3 4", rf_regwrite, rf_reg1, rf_reg2);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (rf_regwrite !== 1'b1 || rf_reg1 !== 4'd3 || rf_writedata !== 16'h1234 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_wr_cycle: we=%b reg1=%h wd=%h valid=%b, required 1 3 1234 0",
               rf_regwrite, rf_reg1, rf_writedata, rsp_valid);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (rf_regwrite !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_after_wr: we=%b valid=%b, required 0 0", rf_regwrite, rsp_valid);
    end
    @(posedge clock); #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || {rsp_data1, rsp_data2} !== e) begin
      n_fail++;
      $display("FAIL swap_rsp: valid=%b data=%h, required 1 %h", rsp_valid, {rsp_data1, rsp_data2}, e);
    end
    @(posedge clock); #1;
    exp_q.push_back({16'h1234, 16'hF0FF});
    send_cmd(OP_READ, 4'd3, 4'd4, 16'h0);
    collect_rsp(d1, d2, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2 || {d1, d2} !== e) begin
      n_fail++;
      $display("FAIL swap_readback: lat=%0d data=%h, required 2 %h", lat, {d1, d2}, e);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_zero_protect();
    logic [DATA_W-1:0] d1, d2;
    logic [2*DATA_W-1:0] e;
    int lat;
    int we_seen;
    we_seen = 0;
    send_cmd(OP_WRITE, 4'd0, 4'd0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      if (rf_regwrite !== 1'b0) we_seen++;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (we_seen !== 0) begin
      n_fail++;
      $display("FAIL zero_protect_we: regwrite high %0d cycles, required 0", we_seen);
    end
    exp_q.push_back({16'h0000, 16'h7B18});
    send_cmd(OP_READ, 4'd0, 4'd1, 16'h0);
    collect_rsp(d1, d2, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2 || {d1, d2} !== e) begin
      n_fail++;
      $display("FAIL zero_protect_read: lat=%0d data=%h, required 2 %h", lat, {d1, d2}, e);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d1, d2;
    logic [2*DATA_W-1:0] e;
    int lat;
    int bad;
    rsp_ready = 1'b0;
    exp_q.push_back({16'h246B, 16'h7B18});
    send_cmd(OP_READ, 4'd2, 4'd1, 16'h0);
    collect_rsp(d1, d2, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2 || {d1, d2} !== e) begin
      n_fail++;
      $display("FAIL bp_first: lat=%0d data=%h, required 2 %h", lat, {d1, d2}, e);
    end
    // A competing command must be refused while the response is pending.
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_ra    = 4'd9;
    cmd_rb    = 4'd9;
    cmd_wdata = 16'hDEAD;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (rsp_valid !== 1'b1 || {rsp_data1, rsp_data2} !== e || cmd_ready !== 1'b0 ||
          rf_regwrite !== 1'b0 || rf_reg1 !== 4'd2 || rf_reg2 !== 4'd1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0 (data=%h ready=%b reg1=%h)",
               bad, {rsp_data1, rsp_data2}, cmd_ready, rf_reg1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || mem[9] !== 16'h9999) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b mem9=%h, required 0 1 9999", rsp_valid, cmd_ready, mem[9]);
    end
  endtask

  task automatic test_reset_abort();
    logic [DATA_W-1:0] d1, d2;
    logic [2*DATA_W-1:0] e;
    int lat;
    send_cmd(OP_WRITE, 4'd7, 4'd0, 16'hAAAA);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (rf_regwrite !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_async: we=%b valid=%b ready=%b st=%0d, required 0 0 0 0",
               rf_regwrite, rsp_valid, cmd_ready, dbg_state);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recover: ready=%b valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    exp_q.push_back({16'h00FF, 16'h0000});
    send_cmd(OP_READ, 4'd7, 4'd0, 16'h0);
    collect_rsp(d1, d2, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2 || {d1, d2} !== e) begin
      n_fail++;
      $display("FAIL abort_readback: lat=%0d data=%h, required 2 %h", lat, {d1, d2}, e);
    end
    @(posedge clock); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_ra    = '0;
    cmd_rb    = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;

    test_reset();
    test_nop();
    test_read();
    test_write_read();
    test_swap();
    test_zero_protect();
    test_backpressure();
    test_reset_abort();

    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Command sequencer that drives the 16×16-bit register file's port set: `Reg1`, `Reg2`, `WriteData`, `regwrite`, `ReadData1`, `ReadData2`. It accepts READ, WRITE and SWAP commands from the datapath over a valid/ready handshake. It sequences the register file's posedge-write / negedge-read timing and returns read results over a second valid/ready handshake. It sits between the control unit and the register file.

## Interface
- `DATA_W`, 16, register data width
- `ADDR_W`, 4, register index width
- `ZERO_PROTECT`, 1, when 1, writes to index 0 are suppressed (`rf_regwrite` held 0)
- `clock`  in  1  single system clock
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  2  00 NOP, 01 READ, 10 WRITE, 11 SWAP
- `cmd_ra`  in  ADDR_W  first index: read port 1 and write target
- `cmd_rb`  in  ADDR_W  second index: read port 2
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  read response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_data1`, `rsp_data2`  out  DATA_W  values read at `cmd_ra` and `cmd_rb`
- `rf_reg1`, `rf_reg2`  out  ADDR_W  to register file `Reg1` / `Reg2`
- `rf_writedata`  out  DATA_W  to register file `WriteData`
- `rf_regwrite`  out  1  to register file `regwrite`
- `rf_readdata1`, `rf_readdata2`  in  DATA_W  from register file `ReadData1` / `ReadData2`

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE
  - `cmd_ready` = 1.
  - A handshake is `cmd_valid & cmd_ready` at a posedge.
  - Latch `ra`, `rb`, `wdata` and `op`.
  - READ or SWAP → RD. WRITE → WR. NOP is consumed and the state stays IDLE.
- RD
  - Drive `rf_reg1`=ra, `rf_reg2`=rb, `rf_regwrite`=0.
  - The register file samples at the negedge inside this cycle.
  - At the ending posedge, capture `rf_readdata1/2` into `rsp_data1/2`.
  - READ → RESP. SWAP → WR.
- WR
  - Drive `rf_reg1`=ra, `rf_writedata`=wdata.
  - `rf_regwrite`=1 for exactly this one cycle, or 0 if `ZERO_PROTECT` and ra==0.
  - Next state: RESP if op was SWAP, else IDLE.
- RESP
  - `rsp_valid`=1.
  - `rsp_data1/2` are held stable until `rsp_valid & rsp_ready`, then → IDLE.
- SWAP returns the pre-write values: the read completes before the write cycle.
- WRITE produces no response.
- `cmd_ready`=0 in RD, WR and RESP, so at most one command is in flight.
- Outside RD and WR, `rf_reg1/2` hold their last values and `rf_regwrite`=0.

## Timing
- Reset (async, `reset`=0):
  - state IDLE.
  - `cmd_ready`, `rsp_valid`, `rf_regwrite` = 0.
  - `rf_reg1`, `rf_reg2` = 0; `rf_writedata`, `rsp_data1`, `rsp_data2` = 0.
  - `cmd_ready` rises at the first posedge after reset deasserts.
- All outputs are registered. `rf_*` change only on posedge, so they are stable at the register file's negedge sample point.
- READ accepted at posedge E0: RD spans E0–E1; `rsp_valid` high from E2.
- WRITE accepted at E0: `rf_regwrite` high E0–E1; the register updates at E1; `cmd_ready` is high again from E2.
- SWAP accepted at E0: RD E0–E1, WR E1–E2, `rsp_valid` from E3.
- A read issued after a write to the same index returns the new value, since writes complete before the next command is accepted.
- `rsp_ready` held high: the response lasts one cycle and the next command is accepted at the following posedge.
- Reset asserted mid-operation aborts the command: no response, `rf_regwrite` drops immediately.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_W` / `ADDR_W` defaults.
  - `cmd_op` encodings: `OP_NOP`, `OP_READ`, `OP_WRITE`, `OP_SWAP`.
  - FSM state enum.
- Single module; no sub-module is warranted.

## Test plan
- Reset, then READ ra=1 rb=2 → `rsp_data1`=16'h7B18, `rsp_data2`=16'h246B, `rsp_valid` two cycles after acceptance.
- WRITE ra=5 wdata=16'hBEEF, then READ ra=5 rb=6 → 16'hBEEF, 16'h6666; `rf_regwrite` high exactly one cycle.
- SWAP ra=3 rb=4 wdata=16'h1234 → response 16'hFF0F, 16'hF0FF; a following READ ra=3 returns 16'h1234.
- WRITE ra=0 wdata=16'hFFFF with `ZERO_PROTECT`=1 → `rf_regwrite` never asserts; READ ra=0 returns 16'h0000.
- READ with `rsp_ready` held low for 5 cycles → `rsp_data` stable, `cmd_ready`=0 throughout, no new `rf_*` activity.
- Assert `reset` during WR of a WRITE to index 7 → `rf_regwrite` drops asynchronously, no response; after release, READ ra=7 returns 16'h00FF.
